fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 66 ++++++
 rtl/fifo_wr_arbiter.sv | 108 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared constants for the multi-requester write FIFO: default sizing and the
// widths derived from it (pointer, occupancy counter, requester id).
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int DEPTH_DEF = 16;
    localparam int WIDTH_DEF = 8;

    localparam int PTR_W = $clog2(DEPTH_DEF);
    localparam int CNT_W = PTR_W + 1;
    localparam int ID_W  = $clog2(NREQ_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter holding the index of the last granted requester. The
// search starts one past that index and wraps.
//   clk  : clock
//   rst  : synchronous active-high reset (requester 0 gets top priority)
//   req  : per-requester request vector
//   en   : grant enable; gnt is forced to zero when low
//   upd  : a grant is being consumed this cycle; advance the pointer
//   gnt  : one-hot combinational grant
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    input  logic            upd,
    output logic [NREQ-1:0] gnt
);
    localparam int IW = $clog2(NREQ);

    logic [IW-1:0]   last;
    logic [IW:0]     shamt;
    logic [NREQ-1:0] rot;
    logic [NREQ-1:0] oh;
    logic            found;
    logic [IW-1:0]   gidx;

    // Rotate the request vector so bit 0 is the highest-priority requester,
    // pick the lowest set bit, then rotate the one-hot back into place.
    always_comb begin
        shamt = {1'b0, last} + 1'b1;
        rot   = NREQ'({req, req} >> shamt);
        oh    = '0;
        found = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (rot[j] && !found) begin
                oh[j] = 1'b1;
                found = 1'b1;
            end
        end
        gnt = '0;
        if (en) begin
            gnt = NREQ'(({oh, oh} << shamt) >> NREQ);
        end
    end

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) gidx = IW'(i);
        end
    end

    // Reset to the top index so the first search starts at requester 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= IW'(NREQ - 1);
        end else if (upd && (|gnt)) begin
            last <= gidx;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// FIFO with NREQ round-robin arbitrated write ports and one read port. Each
// entry stores the data together with the index of the requester that wrote it.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   req      : per-requester write request (level)
//   req_data : requester i data in [i*WIDTH +: WIDTH]
//   gnt      : one-hot combinational grant; write happens on the same edge
//   rinc     : read request
//   rdata    : read data, valid with rvalid
//   rid      : source requester of rdata
//   rvalid   : high the cycle after an accepted read
//   wfull    : occupancy == DEPTH
//   rempty   : occupancy == 0
//   count    : current occupancy
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         gnt,
    input  logic                    rinc,
    output logic [WIDTH-1:0]        rdata,
    output logic [$clog2(NREQ)-1:0] rid,
    output logic                    rvalid,
    output logic                    wfull,
    output logic                    rempty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam int IW = $clog2(NREQ);
    localparam int CW = PW + 1;
    localparam int EW = IW + WIDTH;

    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [EW-1:0]    mem [DEPTH];
    logic             arb_en;
    logic             wr_en;
    logic             rd_en;
    logic [IW-1:0]    widx;
    logic [WIDTH-1:0] wdata;

    // Flags come from the registered count only, so a read accepted while
    // full cannot open a same-cycle write slot.
    assign wfull  = (count == CW'(DEPTH));
    assign rempty = (count == '0);

    assign arb_en = ~rst & ~wfull;
    assign wr_en  = |gnt;
    assign rd_en  = rinc & ~rempty & ~rst;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .en  (arb_en),
        .upd (wr_en),
        .gnt (gnt)
    );

    always_comb begin
        widx  = '0;
        wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                widx  = IW'(i);
                wdata = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_en;
            if (wr_en) wptr <= wptr + PW'(1);
            if (rd_en) rptr <= rptr + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage and read register carry no reset; stale contents are unreachable
    // once the pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= {widx, wdata};
        if (rd_en) {rid, rdata} <= mem[rptr];
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
    localparam int NREQ  = 4;
    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic                  rinc;
    logic [WIDTH-1:0]      rdata;
    logic [1:0]            rid;
    logic                  rvalid;
    logic                  wfull;
    logic                  rempty;
    logic [4:0]            count;

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .rinc     (rinc),
        .rdata    (rdata),
        .rid      (rid),
        .rvalid   (rvalid),
        .wfull    (wfull),
        .rempty   (rempty),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {id, data} entries plus the last granted index.
    typedef struct packed {
        logic [1:0] id;
        logic [7:0] d;
    } ent_t;

    ent_t q[$];
    int   last_g;
    bit   exp_rv;
    ent_t exp_rd;

    task automatic model_reset();
        q.delete();
        last_g = NREQ - 1;
        exp_rv = 1'b0;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 4'b1111;
        rinc = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rempty", 32'(rempty), 32'd1);
        chk("rst_wfull", 32'(wfull), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        rst  = 1'b0;
        req  = '0;
        rinc = 1'b0;
        model_reset();
    endtask

    // One cycle against the model. Called at posedge+1; returns at next posedge+1.
    task automatic mstep(input logic [3:0] r, input logic ri, input logic [31:0] dat);
        logic [3:0] eg;
        int         gi;
        bit         rd;
        req      = r;
        rinc     = ri;
        req_data = dat;
        #1;
        eg = '0;
        gi = -1;
        if (q.size() < DEPTH) begin
            for (int k = 1; k <= NREQ; k++) begin
                int idx;
                idx = (last_g + k) % NREQ;
                if (r[idx] && gi < 0) gi = idx;
            end
        end
        if (gi >= 0) eg[gi] = 1'b1;
        chk("m_gnt", 32'(gnt), 32'(eg));
        chk("m_count", 32'(count), 32'(q.size()));
        chk("m_wfull", 32'(wfull), 32'(q.size() == DEPTH));
        chk("m_rempty", 32'(rempty), 32'(q.size() == 0));
        chk("m_rvalid", 32'(rvalid), 32'(exp_rv));
        if (exp_rv) chk("m_rdata", {22'd0, rid, rdata}, {22'd0, exp_rd});
        rd = ri && (q.size() > 0);
        if (rd) exp_rd = q.pop_front();
        exp_rv = rd;
        if (gi >= 0) begin
            q.push_back({2'(gi), dat[gi*8 +: 8]});
            last_g = gi;
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] req;
        logic       rinc;
        logic [3:0] gnt;
        int         cnt;
        logic       rv;
        int         rid;
    } vec_t;

    vec_t tbl[21];

    function automatic logic [7:0] data_of(input int i);
        return 8'(8'h05 + 8'h10 * i);
    endfunction

    initial begin
        rst      = 1'b1;
        req      = '0;
        rinc     = 1'b0;
        req_data = '0;
        model_reset();

        // round-robin, read-back order, skip, empty-with-rinc corners
        tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 0, 1'b0, 0};
        tbl[1]  = '{4'b1111, 1'b0, 4'b0010, 1, 1'b0, 0};
        tbl[2]  = '{4'b1111, 1'b0, 4'b0100, 2, 1'b0, 0};
        tbl[3]  = '{4'b1111, 1'b0, 4'b1000, 3, 1'b0, 0};
        tbl[4]  = '{4'b0000, 1'b1, 4'b0000, 4, 1'b0, 0};
        tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 3, 1'b1, 0};
        tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 2, 1'b1, 1};
        tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1, 1'b1, 2};
        tbl[8]  = '{4'b0000, 1'b0, 4'b0000, 0, 1'b1, 3};
        tbl[9]  = '{4'b0010, 1'b0, 4'b0010, 0, 1'b0, 0};
        tbl[10] = '{4'b1001, 1'b0, 4'b1000, 1, 1'b0, 0};
        tbl[11] = '{4'b1001, 1'b0, 4'b0001, 2, 1'b0, 0};
        tbl[12] = '{4'b0000, 1'b0, 4'b0000, 3, 1'b0, 0};
        tbl[13] = '{4'b0000, 1'b1, 4'b0000, 3, 1'b0, 0};
        tbl[14] = '{4'b0000, 1'b1, 4'b0000, 2, 1'b1, 1};
        tbl[15] = '{4'b0000, 1'b1, 4'b0000, 1, 1'b1, 3};
        tbl[16] = '{4'b0000, 1'b1, 4'b0000, 0, 1'b1, 0};
        tbl[17] = '{4'b0100, 1'b1, 4'b0100, 0, 1'b0, 0};
        tbl[18] = '{4'b0000, 1'b0, 4'b0000, 1, 1'b0, 0};
        tbl[19] = '{4'b0000, 1'b1, 4'b0000, 1, 1'b0, 0};
        tbl[20] = '{4'b0000, 1'b0, 4'b0000, 0, 1'b1, 2};

        @(posedge clk);
        #1;
        do_reset();
        req_data = {data_of(3), data_of(2), data_of(1), data_of(0)};
        for (int i = 0; i < 21; i++) begin
            req  = tbl[i].req;
            rinc = tbl[i].rinc;
            #1;
            chk($sformatf("t%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("t%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("t%0d_rempty", i), 32'(rempty), 32'(tbl[i].cnt == 0));
            chk($sformatf("t%0d_wfull", i), 32'(wfull), 32'(tbl[i].cnt == DEPTH));
            chk($sformatf("t%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
            if (tbl[i].rv) begin
                chk($sformatf("t%0d_rid", i), 32'(rid), 32'(tbl[i].rid));
                chk($sformatf("t%0d_rdata", i), 32'(rdata), 32'(data_of(tbl[i].rid)));
            end
            @(posedge clk);
            #1;
        end

        // full: write blocked on the read cycle, resumes on the next
        do_reset();
        for (int i = 0; i < DEPTH; i++) mstep(4'b1111, 1'b0, $urandom);
        chk("full_count", 32'(count), 32'd16);
        chk("full_flag", 32'(wfull), 32'd1);
        mstep(4'b1111, 1'b1, $urandom);
        chk("full_rd_count", 32'(count), 32'd15);
        mstep(4'b1111, 1'b0, $urandom);
        chk("full_refill_count", 32'(count), 32'd16);
        for (int i = 0; i < DEPTH + 2; i++) mstep(4'b0000, 1'b1, 32'd0);

        // wrap: steady stream at half occupancy
        do_reset();
        for (int i = 0; i < DEPTH / 2; i++) mstep(4'($urandom_range(1, 15)), 1'b0, $urandom);
        for (int i = 0; i < 40; i++) begin
            mstep(4'($urandom_range(1, 15)), 1'b1, $urandom);
            chk("wrap_count", 32'(count), 32'(DEPTH / 2));
        end

        // random traffic with a mid-run reset
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            mstep(4'($urandom), 1'($urandom_range(0, 2) == 0 ? 0 : ($urandom_range(0, 1))),
                  $urandom);
        end
        for (int i = 0; i < DEPTH + 2; i++) mstep(4'b0000, 1'b1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
